// File: rtl/face_frame_sequencer.sv
// -----------------------------------------------------------------------------
// face_frame_sequencer
//
// Sequences one frame through the face_reader filter. The block accepts
// IMG_WIDTH*IMG_HEIGHT RGB pixels from the source and registers them onto the
// filter load bus, enables processing, then forwards the filter's mask stream
// and captures the first centroid the filter reports. It also flags a filter
// that never finishes (timeout) and a mask stream of the wrong length.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   start                    begin a frame (sampled only while idle)
//   s_valid / s_ready        source pixel handshake
//   s_r, s_g, s_b            source pixel channels
//   filt_r, filt_g, filt_b   registered pixel presented to the filter
//   filt_enable              filter load enable
//   filt_process             filter processing enable
//   filt_pixel, filt_finish  filter mask output and its streaming flag
//   filt_cx, filt_cy         filter centroid
//   filt_centroid_ready      filter centroid valid
//   mask_valid, mask_data    forwarded mask stream (one-cycle latency)
//   centroid_x, centroid_y   captured centroid
//   centroid_valid           centroid captured this frame (sticky)
//   busy                     sequencer is not idle
//   done                     one-cycle pulse at successful frame completion
//   err_timeout              filter did not finish in time (sticky)
//   err_length               mask stream length != frame size (sticky)
//
// States
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; flags from the last frame stay visible
//   LOAD    | accepting source pixels into the filter
//   WAIT    | filter processing, counting cycles until filt_finish
//   DRAIN   | forwarding mask pixels while filt_finish is high
//   DONE    | one-cycle completion pulse
//   ERROR   | one-cycle recovery after a timeout, no done pulse
// -----------------------------------------------------------------------------
module face_frame_sequencer #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256,
  parameter int DEPTH      = 8,
  parameter int TIMEOUT    = 1048576,
  parameter int CNT_W      = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DEPTH-1:0] s_r,
  input  logic [DEPTH-1:0] s_g,
  input  logic [DEPTH-1:0] s_b,
  output logic [DEPTH-1:0] filt_r,
  output logic [DEPTH-1:0] filt_g,
  output logic [DEPTH-1:0] filt_b,
  output logic             filt_enable,
  output logic             filt_process,
  input  logic [DEPTH-1:0] filt_pixel,
  input  logic             filt_finish,
  input  logic [7:0]       filt_cx,
  input  logic [7:0]       filt_cy,
  input  logic             filt_centroid_ready,
  output logic             mask_valid,
  output logic [DEPTH-1:0] mask_data,
  output logic [7:0]       centroid_x,
  output logic [7:0]       centroid_y,
  output logic             centroid_valid,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic             err_length
);

  localparam logic [CNT_W-1:0] N_PIX    = CNT_W'(IMG_WIDTH * IMG_HEIGHT);
  localparam logic [CNT_W-1:0] N_LAST   = CNT_W'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] filt_r_q, filt_r_d;
  logic [DEPTH-1:0] filt_g_q, filt_g_d;
  logic [DEPTH-1:0] filt_b_q, filt_b_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0] mask_cnt_q, mask_cnt_d;
  logic             mask_valid_q, mask_valid_d;
  logic [DEPTH-1:0] mask_data_q, mask_data_d;
  logic [7:0]       cx_q, cx_d;
  logic [7:0]       cy_q, cy_d;
  logic             cvalid_q, cvalid_d;
  logic             err_tmo_q, err_tmo_d;
  logic             err_len_q, err_len_d;

  logic             in_stream;

  // Filter enables are decoded straight from the state register so that an
  // asynchronous reset removes them without waiting for a clock edge.
  assign s_ready      = (state_q == S_LOAD);
  assign filt_enable  = (state_q == S_LOAD) || (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign filt_process = (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign in_stream    = (state_q == S_WAIT) || (state_q == S_DRAIN);

  assign filt_r         = filt_r_q;
  assign filt_g         = filt_g_q;
  assign filt_b         = filt_b_q;
  assign mask_valid     = mask_valid_q;
  assign mask_data      = mask_data_q;
  assign centroid_x     = cx_q;
  assign centroid_y     = cy_q;
  assign centroid_valid = cvalid_q;
  assign err_timeout    = err_tmo_q;
  assign err_length     = err_len_q;

  always_comb begin
    state_d      = state_q;
    filt_r_d     = filt_r_q;
    filt_g_d     = filt_g_q;
    filt_b_d     = filt_b_q;
    pix_cnt_d    = pix_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    mask_cnt_d   = mask_cnt_q;
    mask_valid_d = 1'b0;
    mask_data_d  = mask_data_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    cvalid_d     = cvalid_q;
    err_tmo_d    = err_tmo_q;
    err_len_d    = err_len_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          pix_cnt_d  = '0;
          tmo_cnt_d  = '0;
          mask_cnt_d = '0;
          cvalid_d   = 1'b0;
          err_tmo_d  = 1'b0;
          err_len_d  = 1'b0;
        end
      end

      S_LOAD: begin
        if (s_valid) begin
          filt_r_d = s_r;
          filt_g_d = s_g;
          filt_b_d = s_b;
          if (pix_cnt_q != N_PIX) begin
            pix_cnt_d = pix_cnt_q + CNT_ONE;
          end
          if (pix_cnt_q >= N_LAST) begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        // A finish arriving on the last allowed cycle still counts as success.
        if (filt_finish) begin
          state_d = S_DRAIN;
        end else if (tmo_cnt_q >= TMO_LAST) begin
          state_d   = S_ERROR;
          err_tmo_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_ONE;
        end
      end

      S_DRAIN: begin
        if (!filt_finish) begin
          state_d = S_DONE;
          if (mask_cnt_q != N_PIX) begin
            err_len_d = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      S_ERROR: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Mask forwarding: the WAIT->DRAIN cycle already carries the first pixel.
    if (in_stream && filt_finish) begin
      mask_valid_d = 1'b1;
      mask_data_d  = filt_pixel;
      if (mask_cnt_q != CNT_MAX) begin
        mask_cnt_d = mask_cnt_q + CNT_ONE;
      end
      // Surplus pixels are still forwarded, but the frame is marked bad.
      if (mask_cnt_q >= N_PIX) begin
        err_len_d = 1'b1;
      end
    end

    // Only the first centroid report of a frame is kept.
    if (in_stream && filt_centroid_ready && !cvalid_q) begin
      cx_d     = filt_cx;
      cy_d     = filt_cy;
      cvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      filt_r_q     <= '0;
      filt_g_q     <= '0;
      filt_b_q     <= '0;
      pix_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      mask_cnt_q   <= '0;
      mask_valid_q <= 1'b0;
      mask_data_q  <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      cvalid_q     <= 1'b0;
      err_tmo_q    <= 1'b0;
      err_len_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      filt_r_q     <= filt_r_d;
      filt_g_q     <= filt_g_d;
      filt_b_q     <= filt_b_d;
      pix_cnt_q    <= pix_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      mask_cnt_q   <= mask_cnt_d;
      mask_valid_q <= mask_valid_d;
      mask_data_q  <= mask_data_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      cvalid_q     <= cvalid_d;
      err_tmo_q    <= err_tmo_d;
      err_len_q    <= err_len_d;
    end
  end

endmodule

// File: doc/face_frame_sequencer.md
Name: face_frame_sequencer

Overview:
- Controller that sequences one frame through the face_reader filter: streams RGB pixels in, raises process enable, captures the mask stream and centroid, flags timeout/length errors.
- Sits between the pixel source (frame buffer/camera) and face_reader; replaces bench-driven enable sequencing with synthesizable control.

Parameters:
- IMG_WIDTH, 256, pixels per line
- IMG_HEIGHT, 256, lines per frame
- DEPTH, 8, bits per colour channel and mask pixel
- TIMEOUT, 1048576, max cycles waiting for filter_finish after processing starts
- CNT_W, 21, width of pixel/timeout counters (must hold max(IMG_WIDTH*IMG_HEIGHT, TIMEOUT))

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  begin frame; sampled only in IDLE
- s_valid  in  1  source pixel valid
- s_ready  out  1  sequencer accepts pixel
- s_r, s_g, s_b  in  DEPTH each  source pixel channels
- filt_r, filt_g, filt_b  out  DEPTH each  registered pixel to filter
- filt_enable  out  1  filter load enable
- filt_process  out  1  filter processing enable
- filt_pixel  in  DEPTH  filter mask output
- filt_finish  in  1  filter output-streaming flag
- filt_cx, filt_cy  in  8 each  filter centroid
- filt_centroid_ready  in  1  filter centroid valid
- mask_valid  out  1  mask pixel valid (no backpressure)
- mask_data  out  DEPTH  mask pixel
- centroid_x, centroid_y  out  8 each  captured centroid
- centroid_valid  out  1  sticky until next start
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at frame completion
- err_timeout  out  1  sticky until next start
- err_length  out  1  mask count != IMG_WIDTH*IMG_HEIGHT; sticky until next start

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0. Reset mid-frame aborts immediately; filt_enable/filt_process drop asynchronously.
- States: IDLE, LOAD, WAIT, DRAIN, DONE, ERROR.
- IDLE: start=1 -> LOAD; clears centroid_valid, err_*, counters. start while busy ignored.
- LOAD: s_ready=1 (combinational from state). filt_enable=1. On s_valid&s_ready: filt_r/g/b <= s_r/g/b next edge, pix_cnt++. Source stalls (s_valid=0) hold filt_* unchanged. Accepting pixel N-1 (N=IMG_WIDTH*IMG_HEIGHT) -> WAIT; s_ready=0 from that next cycle.
- WAIT: filt_enable=1, filt_process=1 from first WAIT cycle; tmo_cnt++ each cycle. filt_finish=1 -> DRAIN (that cycle's filt_pixel is captured). tmo_cnt reaching TIMEOUT-1 without finish -> ERROR, err_timeout=1.
- DRAIN: each cycle filt_finish=1: mask_valid<=1, mask_data<=filt_pixel (1-cycle latency), mask_cnt++. filt_finish=0 -> DONE; err_length set if mask_cnt != N. Mask pixels beyond N are still forwarded but set err_length.
- DONE: done=1 for one cycle, filt_enable/filt_process=0 -> IDLE.
- ERROR: filt_enable/filt_process=0, hold one cycle -> IDLE; done not asserted.
- Centroid: in WAIT or DRAIN, first cycle with filt_centroid_ready=1 and centroid_valid=0 latches filt_cx/cy, centroid_valid<=1 next edge. Later centroid_ready pulses ignored. Ready in LOAD/IDLE ignored.
- Simultaneous: finish and centroid_ready same cycle -> both captured. Timeout limit and finish same cycle -> finish wins.
- Counters wrap never: sized by CNT_W; pix_cnt saturates at N.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=4, source valid every cycle, filter model finishes 5 cycles after filt_process and streams 16 pixels 0..15 -> s_ready high exactly 16 cycles, mask_data 0..15 on 16 consecutive mask_valid cycles, done pulses once, err_* = 0.
- Same frame with s_valid toggling 1/0 -> 16 accepted pixels, filt_r/g/b change only on accept cycles, filt_process rises only after 16th accept.
- Filter raises centroid_ready with (0x12,0x34) mid-DRAIN, then (0x56,0x78) later -> centroid_x/y=0x12/0x34, centroid_valid=1 until next start.
- TIMEOUT=20, filter never asserts finish -> err_timeout=1 at cycle 20 of WAIT, done stays 0, returns to IDLE, busy=0.
- Filter streams 15 mask pixels -> done pulse with err_length=1; next start clears err_length.
- rst asserted during LOAD after 7 pixels -> all outputs 0 immediately; subsequent start loads full 16 pixels from count 0.
